// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit holds the master side; the memory model holds the slave side.
interface fetch_unit_if;
    logic        imem_req;   // request outstanding
    logic [31:0] imem_addr;  // word-aligned request address
    logic        imem_ack;   // request complete, data valid this cycle
    logic [31:0] imem_data;  // instruction word

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID pipeline register.
// Owns the PC, runs the imem request/ack handshake and presents one instruction
// at a time, honouring ID-stage hazard holds and taken-branch redirects.
// Optional feature: define IMEM_BYPASS_EN to present an acked word in the same
// cycle it arrives (one instruction per cycle with a zero-wait memory).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,         // asynchronous, active low
    input  logic          start_i,
    input  logic          hazard_i,
    input  logic          branch_i,
    input  logic [31:0]   branch_pc_i,
    input  logic [11:0]   branch_imm_i,
    fetch_unit_if.master  imem,
    output logic [31:0]   pc_o,
    output logic [31:0]   inst_o,
    output logic [11:0]   pcIm_o,
    output logic          stall_o,
    output logic          flush_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] inst_q;
    logic        full_q;

    logic [31:0] branch_target;
    logic [31:0] pc_plus4;
    logic        bypass_hit;
    logic        bypass_consume;
    logic        consume;
    logic [31:0] present_word;

    // Branch target and sequential PC, both wrapping modulo 2^32.
    always_comb begin
        branch_target = branch_pc_i + {{19{branch_imm_i[11]}}, branch_imm_i, 1'b0};
        pc_plus4      = pc_q + 32'd4;
    end

    // Select what ID sees this cycle: the buffer, the bypassed ack data, or nothing.
    always_comb begin
`ifdef IMEM_BYPASS_EN
        bypass_hit = (state_q == StFetch) & imem.imem_ack & ~full_q;
`else
        bypass_hit = 1'b0;
`endif
        bypass_consume = bypass_hit & ~hazard_i & ~branch_i & start_i;
        consume        = full_q & ~hazard_i & ~branch_i & start_i;
        if (full_q) begin
            present_word = inst_q;
        end else if (bypass_hit) begin
            present_word = imem.imem_data;
        end else begin
            present_word = 32'h0;
        end
    end

    // IF/ID side outputs; pcIm is the B-type immediate field layout of the word.
    always_comb begin
        pc_o    = pc_q;
        inst_o  = present_word;
        pcIm_o  = {present_word[31], present_word[7], present_word[30:25], present_word[11:8]};
        stall_o = start_i & ~(full_q | bypass_hit);
        flush_o = branch_i & start_i;
    end

    // Memory side: request decoded from the registered state, address from its register.
    always_comb begin
        imem.imem_req  = (state_q == StFetch) || (state_q == StDrain);
        imem.imem_addr = {req_addr_q[31:2], 2'b00};
    end

    // Fetch FSM: priority is start_i low, then branch_i, then ack/consume.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_q     <= 32'h0;
            full_q     <= 1'b0;
        end else if (!start_i) begin
            pc_q   <= RESET_PC;
            full_q <= 1'b0;
            // An outstanding request cannot be withdrawn; wait out its ack in DRAIN.
            if (((state_q == StFetch) || (state_q == StDrain)) && !imem.imem_ack) begin
                state_q <= StDrain;
            end else begin
                state_q <= StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q    <= StFetch;
                    req_addr_q <= pc_q;
                end
                StFetch: begin
                    if (branch_i) begin
                        pc_q <= branch_target;
                        if (imem.imem_ack) begin
                            // Acked data belongs to the wrong path; reissue at the target.
                            req_addr_q <= branch_target;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (imem.imem_ack) begin
                        if (bypass_consume) begin
                            pc_q       <= pc_plus4;
                            req_addr_q <= pc_plus4;
                        end else begin
                            inst_q  <= imem.imem_data;
                            full_q  <= 1'b1;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (branch_i) begin
                        full_q     <= 1'b0;
                        pc_q       <= branch_target;
                        req_addr_q <= branch_target;
                        state_q    <= StFetch;
                    end else if (consume) begin
                        full_q     <= 1'b0;
                        pc_q       <= pc_plus4;
                        req_addr_q <= pc_plus4;
                        state_q    <= StFetch;
                    end
                end
                StDrain: begin
                    if (imem.imem_ack) begin
                        // Stale data is dropped; the next request goes to the redirected PC.
                        state_q <= StFetch;
                        if (branch_i) begin
                            pc_q       <= branch_target;
                            req_addr_q <= branch_target;
                        end else begin
                            req_addr_q <= pc_q;
                        end
                    end else if (branch_i) begin
                        pc_q <= branch_target;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Handshake rules: a request is held, at a stable address, until it is acked.
    property p_req_held;
        @(posedge clk_i) disable iff (!rst_i)
            (imem.imem_req && !imem.imem_ack) |=> imem.imem_req;
    endproperty
    property p_addr_stable;
        @(posedge clk_i) disable iff (!rst_i)
            (imem.imem_req && !imem.imem_ack) |=> $stable(imem.imem_addr);
    endproperty
    a_req_held:    assert property (p_req_held);
    a_addr_stable: assert property (p_addr_stable);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model, a
// scoreboard of expected request addresses and consumed instructions, and one
// task per scenario with its own inline checks.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        hazard_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_pc_i = 32'h0;
    logic [11:0] branch_imm_i = 12'h0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [11:0] pcIm_o;
    logic        stall_o;
    logic        flush_o;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .hazard_i     (hazard_i),
        .branch_i     (branch_i),
        .branch_pc_i  (branch_pc_i),
        .branch_imm_i (branch_imm_i),
        .imem         (imem_bus.master),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .pcIm_o       (pcIm_o),
        .stall_o      (stall_o),
        .flush_o      (flush_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef IMEM_BYPASS_EN
    localparam int ExpGap = 1;
`else
    localparam int ExpGap = 2;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_consumed = 0;

    // Memory model: acks after ack_delay waiting cycles; data fixed or address-scrambled.
    int unsigned ack_delay = 0;
    int unsigned wait_cnt;
    bit          mem_fixed = 1'b0;
    logic [31:0] mem_fixed_word = 32'h0;

    assign imem_bus.imem_ack  = imem_bus.imem_req && (wait_cnt >= ack_delay);
    assign imem_bus.imem_data = mem_fixed ? mem_fixed_word
                                          : (32'h00A00093 ^ {imem_bus.imem_addr[23:0], 8'h00});

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) wait_cnt <= 0;
        else if (imem_bus.imem_req && !imem_bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem_fixed ? mem_fixed_word : (32'h00A00093 ^ {a[23:0], 8'h00});
    endfunction

    function automatic logic [11:0] pcim_of(input logic [31:0] w);
        return {w[31], w[7], w[30:25], w[11:8]};
    endfunction

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    int          ack_cyc_q[$];

    // Scoreboard monitor: every acked request and every consumed instruction is checked in order.
    logic [31:0] sb_addr, sb_pc, sb_inst;
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                if (imem_bus.imem_req && imem_bus.imem_ack) begin
                    ack_cyc_q.push_back(cyc);
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_addr: unexpected request got=%h want=none",
                                 imem_bus.imem_addr);
                    end else begin
                        sb_addr = exp_addr_q.pop_front();
                        if (imem_bus.imem_addr !== sb_addr) begin
                            bad++;
                            $display("FAIL sb_addr: got=%h want=%h", imem_bus.imem_addr, sb_addr);
                        end
                    end
                end
                if (start_i && !stall_o && !hazard_i && !branch_i) begin
                    n_consumed++;
                    total++;
                    if (exp_pc_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_inst: unexpected consume got pc=%h inst=%h want=none",
                                 pc_o, inst_o);
                    end else begin
                        sb_pc   = exp_pc_q.pop_front();
                        sb_inst = exp_inst_q.pop_front();
                        if (pc_o !== sb_pc || inst_o !== sb_inst || pcIm_o !== pcim_of(sb_inst)) begin
                            bad++;
                            $display("FAIL sb_inst: got pc=%h inst=%h pcim=%h want pc=%h inst=%h pcim=%h",
                                     pc_o, inst_o, pcIm_o, sb_pc, sb_inst, pcim_of(sb_inst));
                        end
                    end
                end
            end
        end
    end

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        start_i = 1'b0;
        hazard_i = 1'b0;
        branch_i = 1'b0;
        branch_pc_i = 32'h0;
        branch_imm_i = 12'h0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic push_inst(input logic [31:0] pc);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(word_at(pc));
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        for (int pass = 0; pass < 2; pass++) begin
            total += 7;
            if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got=%b want=0", imem_bus.imem_req); end
            if (imem_bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got=%h want=0", imem_bus.imem_addr); end
            if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc: got=%h want=0", pc_o); end
            if (inst_o !== 32'h0) begin bad++; $display("FAIL rst_inst: got=%h want=0", inst_o); end
            if (pcIm_o !== 12'h0) begin bad++; $display("FAIL rst_pcim: got=%h want=0", pcIm_o); end
            if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got=%b want=0", stall_o); end
            if (flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush: got=%b want=0", flush_o); end
            // Second pass: released from reset but start_i low, so nothing moves.
            rst_i = 1'b1;
            repeat (3) next();
            @(negedge clk_i);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        mem_fixed = 1'b1;
        mem_fixed_word = 32'h00A00093;
        ack_delay = 0;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        push_inst(32'h0); push_inst(32'h4); push_inst(32'h8);
        ack_cyc_q.delete();
        n_consumed = 0;
        start_i = 1'b1;
        for (int k = 0; k < 20 && n_consumed < 3; k++) begin
            @(negedge clk_i);
            if (!stall_o) begin
                total++;
                if (pcIm_o !== 12'h400) begin bad++; $display("FAIL stream_pcim: got=%h want=400", pcIm_o); end
            end
        end
        total++;
        if (n_consumed !== 3) begin bad++; $display("FAIL stream_timeout: got=%0d want=3 consumed", n_consumed); end
        next();
        start_i = 1'b0;
        repeat (4) next();
        total++;
        if (ack_cyc_q.size() !== 4) begin bad++; $display("FAIL stream_acks: got=%0d want=4", ack_cyc_q.size()); end
        for (int i = 1; i < ack_cyc_q.size(); i++) begin
            total++;
            if (ack_cyc_q[i] - ack_cyc_q[i-1] !== ExpGap) begin
                bad++;
                $display("FAIL stream_gap: got=%0d want=%0d", ack_cyc_q[i] - ack_cyc_q[i-1], ExpGap);
            end
        end
        total++;
        if (exp_addr_q.size() + exp_pc_q.size() !== 0) begin
            bad++; $display("FAIL stream_left: got=%0d want=0 pending", exp_addr_q.size() + exp_pc_q.size());
        end
    endtask

    task automatic test_wait();
`ifdef IMEM_BYPASS_EN
        logic        exp_req[6]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        exp_stall[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_addr[6]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
`else
        logic        exp_req[6]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_stall[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_addr[6]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
        apply_reset();
        mem_fixed = 1'b0;
        ack_delay = 3;
        exp_addr_q = '{32'h0, 32'h4};
        push_inst(32'h0);
        start_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            total++;
            if (imem_bus.imem_req !== exp_req[k] || imem_bus.imem_addr !== exp_addr[k]
                || stall_o !== exp_stall[k]) begin
                bad++;
                $display("FAIL wait_c%0d: got req=%b addr=%h stall=%b want req=%b addr=%h stall=%b",
                         k, imem_bus.imem_req, imem_bus.imem_addr, stall_o,
                         exp_req[k], exp_addr[k], exp_stall[k]);
            end
            next();
        end
        start_i = 1'b0;
        repeat (8) next();
        total++;
        if (exp_addr_q.size() + exp_pc_q.size() !== 0) begin
            bad++; $display("FAIL wait_left: got=%0d want=0 pending", exp_addr_q.size() + exp_pc_q.size());
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        mem_fixed = 1'b0;
        ack_delay = 0;
        exp_addr_q = '{32'h0, 32'h4};
        push_inst(32'h0);
        start_i = 1'b1;
        next();                       // c1: request to 0 acked
        hazard_i = 1'b1;
        next();
        for (int k = 0; k < 2; k++) begin  // c2, c3: held
            @(negedge clk_i);
            total++;
            if (pc_o !== 32'h0 || inst_o !== word_at(32'h0) || pcIm_o !== pcim_of(word_at(32'h0))
                || imem_bus.imem_req !== 1'b0) begin
                bad++;
                $display("FAIL hazard_hold: got pc=%h inst=%h pcim=%h req=%b want pc=0 inst=%h pcim=%h req=0",
                         pc_o, inst_o, pcIm_o, imem_bus.imem_req, word_at(32'h0), pcim_of(word_at(32'h0)));
            end
            next();
        end
        hazard_i = 1'b0;              // c4: consumed
        next();
        hazard_i = 1'b1;              // c5: request to 4, held afterwards
        next();
        @(negedge clk_i);             // c6
        total++;
        if (pc_o !== 32'h4 || inst_o !== word_at(32'h4) || imem_bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL hazard_resume: got pc=%h inst=%h req=%b want pc=4 inst=%h req=0",
                     pc_o, inst_o, imem_bus.imem_req, word_at(32'h4));
        end
        next();
        start_i = 1'b0;
        hazard_i = 1'b0;
        repeat (3) next();
        total++;
        if (exp_addr_q.size() + exp_pc_q.size() !== 0) begin
            bad++; $display("FAIL hazard_left: got=%0d want=0 pending", exp_addr_q.size() + exp_pc_q.size());
        end
    endtask

    task automatic test_branch();
        bit found;
        apply_reset();
        mem_fixed = 1'b0;
        ack_delay = 0;
        exp_addr_q = '{32'h0, 32'h100, 32'h104, 32'h108, 32'hF0};
        push_inst(32'h100); push_inst(32'h104);
        start_i = 1'b1;
        hazard_i = 1'b1;
        repeat (2) next();            // c2: word 0 presented
        branch_i = 1'b1;
        branch_pc_i = 32'h0;
        branch_imm_i = 12'h080;       // target 0x100
        @(negedge clk_i);
        total++;
        if (flush_o !== 1'b1) begin bad++; $display("FAIL branch_flush1: got=%b want=1", flush_o); end
        next();
        branch_i = 1'b0;
        next();                       // c4: 0x100 presented
        hazard_i = 1'b0;
        ack_delay = 3;
        @(negedge clk_i);
        total++;
        if (pc_o !== 32'h100) begin bad++; $display("FAIL branch_redirect: got=%h want=100", pc_o); end
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk_i);
            if (imem_bus.imem_req && imem_bus.imem_addr == 32'h108) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL branch_timeout: got=none want=request to 108"); end
        next();
        branch_i = 1'b1;
        branch_pc_i = 32'h100;
        branch_imm_i = 12'hFF8;       // target 0xF0
        hazard_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (flush_o !== 1'b1 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h108) begin
            bad++;
            $display("FAIL branch_flush2: got flush=%b req=%b addr=%h want flush=1 req=1 addr=108",
                     flush_o, imem_bus.imem_req, imem_bus.imem_addr);
        end
        next();
        branch_i = 1'b0;
        @(negedge clk_i);             // draining the 0x108 request
        total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h108 || pc_o !== 32'hF0
            || stall_o !== 1'b1 || inst_o !== 32'h0 || pcIm_o !== 12'h0) begin
            bad++;
            $display("FAIL branch_drain: got req=%b addr=%h pc=%h stall=%b inst=%h pcim=%h want 1 108 f0 1 0 0",
                     imem_bus.imem_req, imem_bus.imem_addr, pc_o, stall_o, inst_o, pcIm_o);
        end
        repeat (2) next();
        @(negedge clk_i);             // first target request
        total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hF0) begin
            bad++;
            $display("FAIL branch_target_req: got req=%b addr=%h want req=1 addr=f0",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            next();
            @(negedge clk_i);
            if (!imem_bus.imem_req && !stall_o) found = 1'b1;
        end
        total++;
        if (!found || pc_o !== 32'hF0 || inst_o !== word_at(32'hF0)) begin
            bad++;
            $display("FAIL branch_target_inst: got pc=%h inst=%h want pc=f0 inst=%h",
                     pc_o, inst_o, word_at(32'hF0));
        end
        next();
        start_i = 1'b0;
        hazard_i = 1'b0;
        repeat (3) next();
        total++;
        if (exp_addr_q.size() + exp_pc_q.size() !== 0) begin
            bad++; $display("FAIL branch_left: got=%0d want=0 pending", exp_addr_q.size() + exp_pc_q.size());
        end
    endtask

    task automatic test_pcim();
        apply_reset();
        mem_fixed = 1'b1;
        mem_fixed_word = 32'hFE000EE3;
        ack_delay = 0;
        exp_addr_q = '{32'h0};
        start_i = 1'b1;
        hazard_i = 1'b1;
        @(negedge clk_i);             // c0: nothing ready
        total++;
        if (stall_o !== 1'b1 || inst_o !== 32'h0 || pcIm_o !== 12'h0) begin
            bad++;
            $display("FAIL pcim_empty: got stall=%b inst=%h pcim=%h want stall=1 inst=0 pcim=0",
                     stall_o, inst_o, pcIm_o);
        end
        repeat (2) next();
        @(negedge clk_i);             // c2: presented from the buffer
        total++;
        if (stall_o !== 1'b0 || inst_o !== 32'hFE000EE3 || pcIm_o !== 12'hFFE) begin
            bad++;
            $display("FAIL pcim_value: got stall=%b inst=%h pcim=%h want stall=0 inst=fe000ee3 pcim=ffe",
                     stall_o, inst_o, pcIm_o);
        end
        next();
        start_i = 1'b0;
        hazard_i = 1'b0;
        repeat (2) next();
        total++;
        if (exp_addr_q.size() !== 0) begin bad++; $display("FAIL pcim_left: got=%0d want=0", exp_addr_q.size()); end
    endtask

    task automatic test_start_reset();
        apply_reset();
        mem_fixed = 1'b0;
        ack_delay = 0;
        exp_addr_q = '{32'h0, 32'h4, 32'h0};
        push_inst(32'h0);
        start_i = 1'b1;
        hazard_i = 1'b1;
        repeat (2) next();            // c2: word 0 presented, consumed
        hazard_i = 1'b0;
        ack_delay = 3;
        next();                       // c3: request to 4 outstanding
        hazard_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (pc_o !== 32'h4 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL sr_fetch: got pc=%h req=%b addr=%h want pc=4 req=1 addr=4",
                     pc_o, imem_bus.imem_req, imem_bus.imem_addr);
        end
        next();
        start_i = 1'b0;               // c4: halt with request pending
        next();
        @(negedge clk_i);             // c5: draining
        total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4 || pc_o !== 32'h0) begin
            bad++;
            $display("FAIL sr_drain: got req=%b addr=%h pc=%h want req=1 addr=4 pc=0",
                     imem_bus.imem_req, imem_bus.imem_addr, pc_o);
        end
        repeat (2) next();
        @(negedge clk_i);             // c7: idle
        total++;
        if (imem_bus.imem_req !== 1'b0 || pc_o !== 32'h0) begin
            bad++;
            $display("FAIL sr_idle: got req=%b pc=%h want req=0 pc=0", imem_bus.imem_req, pc_o);
        end
        next();
        start_i = 1'b1;
        ack_delay = 0;
        repeat (2) next();            // c9: waiting with word 0 held
        @(negedge clk_i);
        total++;
        if (stall_o !== 1'b0 || inst_o !== word_at(32'h0)) begin
            bad++;
            $display("FAIL sr_restart: got stall=%b inst=%h want stall=0 inst=%h",
                     stall_o, inst_o, word_at(32'h0));
        end
        #1;
        rst_i = 1'b0;
        start_i = 1'b0;
        hazard_i = 1'b0;
        #1;
        total++;
        if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0 || pc_o !== 32'h0
            || inst_o !== 32'h0 || pcIm_o !== 12'h0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin
            bad++;
            $display("FAIL sr_async_rst: got req=%b addr=%h pc=%h inst=%h pcim=%h stall=%b flush=%b want all 0",
                     imem_bus.imem_req, imem_bus.imem_addr, pc_o, inst_o, pcIm_o, stall_o, flush_o);
        end
        next();
        rst_i = 1'b1;
        repeat (2) next();
        total++;
        if (exp_addr_q.size() + exp_pc_q.size() !== 0) begin
            bad++; $display("FAIL sr_left: got=%0d want=0 pending", exp_addr_q.size() + exp_pc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_hazard();
        test_branch();
        test_pcim();
        test_start_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a scenario loses track of the clock.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch front end: the producer side of the IF/ID pipeline register.
- Holds the program counter and runs the instruction-memory request/acknowledge handshake, with memory that may take several cycles to answer.
- Presents one fetched instruction at a time as pc/inst/branch-immediate, plus stall and flush controls for IF/ID.
- Applies hazard holds and taken-branch redirects resolved in ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset and while start_i is low.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  fetch enable; low acts as a synchronous halt/restart.
- hazard_i  in  1  load-use hazard from ID; the presented instruction is not consumed.
- branch_i  in  1  taken branch resolved in ID this cycle.
- branch_pc_i  in  32  PC of the branch instruction.
- branch_imm_i  in  12  B-type immediate of the branch (pcIm from IF/ID).
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request address, word aligned.
- imem_ack_i  in  1  request complete; data valid this cycle.
- imem_data_i  in  32  instruction word.
- pc_o  out  32  PC of the presented instruction.
- inst_o  out  32  presented instruction; 32'h0 when none is ready.
- pcIm_o  out  12  {inst[31], inst[7], inst[30:25], inst[11:8]} of inst_o; 0 when none is ready.
- stall_o  out  1  no instruction ready; IF/ID must hold.
- flush_o  out  1  equals branch_i & start_i (combinational); drives IF/ID flush.

## Operation
- Registers:
  - pc_q: PC of the next or presented instruction.
  - req_addr_q: address of the outstanding request.
  - inst_q, full_q: instruction buffer.
  - state: IDLE, FETCH, WAIT, DRAIN.
- Reset values:
  - pc_q = req_addr_q = RESET_PC, full_q = 0, state = IDLE.
  - Outputs: imem_req_o = 0, imem_addr_o = RESET_PC, pc_o = RESET_PC, inst_o = 0, pcIm_o = 0, stall_o = 0, flush_o = 0.
- Output definitions:
  - imem_req_o = 1 in FETCH and DRAIN.
  - imem_addr_o = req_addr_q; it is stable while imem_req_o is high and no ack has arrived.
  - stall_o = start_i & ~full_q.
  - inst_o = full_q ? inst_q : 0.
  - pc_o = pc_q.
- Consume: full_q & ~hazard_i & ~branch_i & start_i.
- Branch target: branch_pc_i + {{19{branch_imm_i[11]}}, branch_imm_i, 1'b0}, computed modulo 2^32.
- Event priority: start_i low > branch_i > ack/consume.
- start_i low:
  - pc_q ← RESET_PC, full_q ← 0.
  - In FETCH or DRAIN without ack this cycle → DRAIN; otherwise → IDLE.
- IDLE: start_i → FETCH, with req_addr_q ← pc_q.
- FETCH:
  - branch_i with ack: discard data, pc_q ← target, req_addr_q ← target, stay in FETCH.
  - branch_i without ack: pc_q ← target → DRAIN. The old request is not abandoned.
  - ack: inst_q ← imem_data_i, full_q ← 1 → WAIT.
- WAIT:
  - branch_i: full_q ← 0, pc_q ← target, req_addr_q ← target → FETCH.
  - Consume: full_q ← 0, pc_q ← pc_q + 4, req_addr_q ← pc_q + 4 → FETCH.
  - hazard_i: hold everything.
- DRAIN:
  - Request stays up at the old req_addr_q.
  - On ack: discard data, req_addr_q ← pc_q → FETCH if start_i, else IDLE.
  - branch_i in DRAIN: pc_q ← target, stay in DRAIN.
- pc_q + 4 wraps modulo 2^32.

## Timing
- Request asserted the cycle after entering FETCH.
- Ack with no wait: instruction presented (stall_o low) the next cycle.
- Throughput without bypass: one instruction per 2 cycles plus memory wait cycles.
- Branch: flush_o is in the same cycle. The first target request goes out the next cycle from WAIT, or after the outstanding ack from FETCH/DRAIN.
- rst_i asserted mid-transaction returns everything to reset values immediately. The memory is expected to drop its pending ack.

## Configuration
- IMEM_BYPASS_EN defined:
  - In FETCH, an ack with an empty buffer presents imem_data_i combinationally on inst_o/pcIm_o, with stall_o low the same cycle.
  - If consumed that cycle (no hazard_i, no branch_i, start_i high): the buffer is not written, pc_q ← pc_q + 4, req_addr_q ← pc_q + 4, stay in FETCH.
  - If not consumed that cycle: buffer filled → WAIT as normal.
  - Zero-wait throughput is 1 instruction per cycle.
- Not defined:
  - inst_o is driven only from the buffer; behaviour is as in Operation.

## Test plan
- Reset with RESET_PC=0, start_i=1, ack every request after 0 cycles with data 0x00A00093 → imem_addr_o sequence 0x0, 0x4, 0x8; pc_o/inst_o match each word. Ack cycles are 2 apart without the macro and 1 apart with it.
- Ack delayed 3 cycles → imem_addr_o stable and imem_req_o high for 4 cycles; stall_o high until the cycle after ack.
- hazard_i held 2 cycles with an instruction presented → pc_o, inst_o, pcIm_o unchanged, no new request; resumes with pc+4.
- branch_i with branch_pc_i=0x100, branch_imm_i=12'hFF8, while a request to 0x108 is outstanding → flush_o=1 the same cycle, DRAIN until ack, data discarded, next request to 0xF0.
- Presented instruction 0xFE000EE3 → pcIm_o = 12'hFFE; inst_o = 0 and pcIm_o = 0 when stall_o=1.
- start_i dropped during an outstanding request, then rst_i pulsed mid-WAIT → DRAIN then IDLE with pc_o=RESET_PC; after reset, all outputs at reset values.
